sdp_ram: RTL and testbench
==========================

# sdp_ram

Parametrised simple-dual-port RAM with one write port and one independent read port on a single clock. Writes use per-lane byte strobes. Read latency (1 or 2 cycles) and read-during-write behaviour are selectable. After every reset a built-in sequencer clears the whole array. It is the next-generation storage primitive after the single-port RAM, intended for FIFOs, line buffers and register files.

## Interface
- `WIDTH`, 32, data width in bits; must be a multiple of `STRB_WIDTH`.
- `DEPTH`, 12, number of words; need not be a power of two.
- `STRB_WIDTH`, 8, bits covered by one write-strobe lane.
- `RD_LATENCY`, 1, read latency in cycles; legal values are 1 and 2.
- `RDW_MODE`, `RDW_READ_OLD`, same-address read-during-write policy; `RDW_READ_OLD` or `RDW_WRITE_FIRST`.
- `INIT_VALUE`, `'0`, word written to every location during initialisation.
- Derived constants: `LANES` = `WIDTH/STRB_WIDTH`; `AW` = `$clog2(DEPTH)`, minimum 1.

Ports:
- `CLK`, in, 1, single clock; all logic on the rising edge.
- `RST_N`, in, 1, reset; asynchronous and active-low.
- `INIT_DONE`, out, 1, high once initialisation has completed; reset value 0.
- `WR_EN`, in, 1, write request.
- `WR_ADDR`, in, `AW`, write address.
- `WR_DATA`, in, `WIDTH`, write data.
- `WR_STRB`, in, `LANES`, per-lane write enable.
- `RD_EN`, in, 1, read request.
- `RD_ADDR`, in, `AW`, read address.
- `RD_DATA`, out, `WIDTH`, read data; reset value 0; holds its last value between valid reads.
- `RD_VALID`, out, 1, one-cycle pulse marking valid `RD_DATA`; reset value 0.

## Operation
- **States:** `INIT` and `READY`. Reset forces `INIT` with the clear counter at 0.
- **`INIT`:**
  - One location is written with `INIT_VALUE` per cycle, addresses 0 through `DEPTH-1`.
  - After the cycle that writes `DEPTH-1`, the block moves to `READY` and `INIT_DONE` rises.
  - The `INIT` phase lasts exactly `DEPTH` cycles.
- **Requests during `INIT`:** `WR_EN` and `RD_EN` are ignored. Nothing is stored and no `RD_VALID` is produced.
- **Write in `READY`:**
  - Each lane i is updated only where `WR_STRB[i]` is 1.
  - A write with `WR_STRB` equal to 0 is a no-op.
- **Out-of-range addresses (`ADDR >= DEPTH`):**
  - Writes are dropped.
  - Reads return all-zero data with `RD_VALID` still asserted.
- **Read-during-write to the same address in the same cycle:**
  - `RDW_READ_OLD`: the read returns the pre-write word.
  - `RDW_WRITE_FIRST`: per lane, strobed lanes return `WR_DATA` and unstrobed lanes return the old contents.
- **Different-address accesses** in the same cycle are fully independent.
- **Reset asserted mid-operation:**
  - The read pipeline and `RD_VALID` clear immediately.
  - `INIT_DONE` drops.
  - Initialisation restarts from address 0 after release.
  - Array contents are don't-care until initialisation completes.

## Timing
- **Read latency:** a read presented in cycle c returns `RD_DATA` with `RD_VALID` set in cycle c+`RD_LATENCY`. `RD_VALID` lasts exactly one cycle per request.
- **Throughput:** one read and one write may be accepted every cycle with no stalls. Back-to-back reads give back-to-back `RD_VALID`.
- **Write visibility:** a write in cycle c is visible to a read presented in cycle c+1, or in cycle c under `RDW_WRITE_FIRST`.
- **`RD_LATENCY`=2:** adds one output register stage after the array read. The read-during-write resolution is still taken at request time.
- **`INIT_DONE` timing:** with `RST_N` released before edge 0, `INIT_DONE` is high from cycle `DEPTH` onward.
  - The first request accepted is the one presented in cycle `DEPTH`.
- **Reset values:** `INIT_DONE`, `RD_VALID` and `RD_DATA` are all 0.

## Structure
- **Package `sdp_ram_pkg`:**
  - `rdw_mode_e` with values `RDW_READ_OLD` and `RDW_WRITE_FIRST`.
  - `init_state_e` with values `INIT` and `READY`.
  - Helper function `lanes(width, strb)`.
- **Sub-module `sdp_ram_init_seq`:** owns the state register and clear counter. It outputs the clear write enable and address plus `INIT_DONE`.
  - The top level muxes the array write port between the sequencer and the user port.
- **Array:** inferred as registers or block RAM. No vendor primitives.
- **Parameter checks:** elaboration-time assertions on `WIDTH % STRB_WIDTH == 0` and `RD_LATENCY` being 1 or 2.

## Test plan
- **Init clear:** `DEPTH`=12, `INIT_VALUE`=`32'hA5A5_A5A5`, then read all 12 addresses. Require `INIT_DONE` exactly at cycle 12 and every read returning `A5A5_A5A5`.
- **Byte strobes:** write `32'h1122_3344` with strobe `4'b0101` to address 3 (initial contents 0), then read. Require `32'h0022_0044`.
- **Read-during-write:** address 5 holds `32'hDEAD_BEEF`. Write `32'hCAFE_F00D` with strobe `4'b1100` and read address 5 in the same cycle.
  - `RDW_READ_OLD` requires `DEAD_BEEF`.
  - `RDW_WRITE_FIRST` requires `CAFE_BEEF`.
- **Latency and throughput:** `RD_LATENCY`=2, reads of addresses 0–11 on consecutive cycles. Require 12 consecutive `RD_VALID` pulses starting 2 cycles after the first request, with data in order.
- **Out-of-range access:** write `32'hFFFF_FFFF` to address 13, then read address 13. Require data 0 with `RD_VALID`=1, and all 12 in-range words unchanged.
- **Mid-operation reset:** pulse `RST_N` low during a read burst. Require `RD_VALID` to drop asynchronously, `INIT_DONE` to drop, no `RD_VALID` during re-init, and `INIT_DONE` high again 12 cycles after release.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// rtl/sdp_ram_pkg.sv - shared types and helpers for the simple-dual-port RAM
package sdp_ram_pkg;

  typedef enum logic {
    RDW_READ_OLD    = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  function automatic int lanes(input int width, input int strb);
    return width / strb;
  endfunction

endpackage

// File: rtl/sdp_ram_init_seq.sv
// rtl/sdp_ram_init_seq.sv - post-reset clear sequencer, one location per cycle
module sdp_ram_init_seq
  import sdp_ram_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_done
);

  init_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
      else                         cnt_d   = cnt_q + AW'(1);
    end
  end

  always_comb begin
    clr_we    = (state_q == INIT);
    clr_addr  = cnt_q;
    init_done = (state_q == READY);
  end

endmodule

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple-dual-port RAM with byte strobes, selectable read latency and RDW policy
module sdp_ram
  import sdp_ram_pkg::*;
#(
  parameter int                 WIDTH      = 32,
  parameter int                 DEPTH      = 12,
  parameter int                 STRB_WIDTH = 8,
  parameter int                 RD_LATENCY = 1,
  parameter rdw_mode_e          RDW_MODE   = RDW_READ_OLD,
  parameter logic [WIDTH-1:0]   INIT_VALUE = '0,
  localparam int                LANES      = lanes(WIDTH, STRB_WIDTH),
  localparam int                AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic             INIT_DONE,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic [LANES-1:0] WR_STRB,
  input  logic             RD_EN,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID
);

  if (WIDTH % STRB_WIDTH != 0) begin : g_chk_width
    $error("sdp_ram: WIDTH must be a multiple of STRB_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
    $error("sdp_ram: RD_LATENCY must be 1 or 2");
  end

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  sdp_ram_init_seq #(.DEPTH(DEPTH), .AW(AW)) u_init_seq (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (INIT_DONE)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_ok, rd_ok, rd_in_range;
  logic             arr_we;
  logic [AW-1:0]    arr_addr;
  logic [WIDTH-1:0] arr_data;
  logic [LANES-1:0] arr_strb;
  logic [WIDTH-1:0] rd_word;

  // Range checks widen by one bit so a power-of-two DEPTH still compares correctly.
  always_comb begin
    wr_ok       = INIT_DONE & WR_EN & ({1'b0, WR_ADDR} < (AW+1)'(DEPTH));
    rd_ok       = INIT_DONE & RD_EN;
    rd_in_range = ({1'b0, RD_ADDR} < (AW+1)'(DEPTH));
  end

  always_comb begin
    if (clr_we) begin
      arr_we   = 1'b1;
      arr_addr = clr_addr;
      arr_data = INIT_VALUE;
      arr_strb = '1;
    end else begin
      arr_we   = wr_ok;
      arr_addr = WR_ADDR;
      arr_data = WR_DATA;
      arr_strb = WR_STRB;
    end
  end

  always_ff @(posedge CLK) begin
    if (arr_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (arr_strb[i]) mem_q[arr_addr][i*STRB_WIDTH +: STRB_WIDTH] <= arr_data[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[RD_ADDR];
      if (RDW_MODE == RDW_WRITE_FIRST && wr_ok && WR_ADDR == RD_ADDR) begin
        for (int i = 0; i < LANES; i++) begin
          if (WR_STRB[i]) rd_word[i*STRB_WIDTH +: STRB_WIDTH] = WR_DATA[i*STRB_WIDTH +: STRB_WIDTH];
        end
      end
    end
  end

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] d1_q, d1_d;

  always_comb begin
    v1_d = rd_ok;
    d1_d = rd_ok ? rd_word : d1_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] d2_q, d2_d;

    always_comb begin
      v2_d = v1_q;
      d2_d = v1_q ? d1_q : d2_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end

    assign RD_VALID = v2_q;
    assign RD_DATA  = d2_q;
  end else begin : g_lat1
    assign RD_VALID = v1_q;
    assign RD_DATA  = d1_q;
  end

endmodule

// File: tb/tb_sdp_ram.sv
// tb/tb_sdp_ram.sv - scoreboard bench for sdp_ram: read-old/latency-1 and write-first/latency-2 instances
module tb_sdp_ram;
  import sdp_ram_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WR_EN = 1'b0, RD_EN = 1'b0;
  logic [3:0]  WR_ADDR = '0, RD_ADDR = '0, WR_STRB = '0;
  logic [31:0] WR_DATA = '0;

  logic        done_a, done_b, val_a, val_b;
  logic [31:0] data_a, data_b;

  always #5 CLK = ~CLK;

  sdp_ram #(.WIDTH(32), .DEPTH(12), .STRB_WIDTH(8), .RD_LATENCY(1),
            .RDW_MODE(RDW_READ_OLD), .INIT_VALUE(32'hA5A5_A5A5)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .INIT_DONE(done_a),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(data_a), .RD_VALID(val_a));

  sdp_ram #(.WIDTH(32), .DEPTH(12), .STRB_WIDTH(8), .RD_LATENCY(2),
            .RDW_MODE(RDW_WRITE_FIRST), .INIT_VALUE(32'h0)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .INIT_DONE(done_b),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(data_b), .RD_VALID(val_b));

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  logic [31:0] m_a[16], m_b[16];
  logic [31:0] last_a, last_b;
  int          n_assert = 0, n_fail = 0, cyc = 0, init_cnt = 0;
  bit          ready_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (ws[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    ready_m  = 1'b0;
    init_cnt = 0;
    last_a   = '0;
    last_b   = '0;
    for (int i = 0; i < 16; i++) begin
      m_a[i] = 32'hA5A5_A5A5;
      m_b[i] = 32'h0;
    end
  endtask

  task automatic check_out();
    chk("a_init_done", {31'b0, done_a}, {31'b0, ready_m});
    chk("b_init_done", {31'b0, done_b}, {31'b0, ready_m});
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      chk("a_valid", {31'b0, val_a}, 32'd1);
      chk("a_data", data_a, q_a[0].data);
      last_a = q_a[0].data;
      void'(q_a.pop_front());
    end else begin
      chk("a_no_valid", {31'b0, val_a}, 32'd0);
      chk("a_hold", data_a, last_a);
    end
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      chk("b_valid", {31'b0, val_b}, 32'd1);
      chk("b_data", data_b, q_b[0].data);
      last_b = q_b[0].data;
      void'(q_b.pop_front());
    end else begin
      chk("b_no_valid", {31'b0, val_b}, 32'd0);
      chk("b_hold", data_b, last_b);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    if (RST_N && !ready_m) begin
      init_cnt++;
      if (init_cnt == 12) ready_m = 1'b1;
    end
    @(negedge CLK);
    check_out();
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic re, input logic [3:0] ra);
    logic [31:0] rv_a, rv_b;
    WR_EN = we; WR_ADDR = wa; WR_DATA = wd; WR_STRB = ws;
    RD_EN = re; RD_ADDR = ra;
    if (ready_m && RST_N) begin
      if (re) begin
        rv_a = (ra < 12) ? m_a[ra] : 32'h0;
        rv_b = (ra < 12) ? m_b[ra] : 32'h0;
        if (we && wa == ra && ra < 12) rv_b = merge(rv_b, wd, ws);
        q_a.push_back('{data: rv_a, due: cyc + 1});
        q_b.push_back('{data: rv_b, due: cyc + 2});
      end
      if (we && wa < 12) begin
        m_a[wa] = merge(m_a[wa], wd, ws);
        m_b[wa] = merge(m_b[wa], wd, ws);
      end
    end
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] ra);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, ra);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws);
    drive(1'b1, wa, wd, ws, 1'b0, 4'd0);
  endtask

  initial begin
    int n_init;
    model_reset();
    for (int i = 0; i < 3; i++) idle();
    RST_N = 1'b1;

    // Requests throughout initialisation must be dropped, including the last init cycle.
    n_init = 0;
    while (!ready_m && n_init < 40) begin
      drive(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd2);
      n_init++;
    end
    chk("init_cycles", n_init, 32'd12);

    for (int a = 0; a < 12; a++) rd(4'(a));
    idle(); idle();

    wr(4'd3, 32'h1122_3344, 4'b0101);
    rd(4'd3);
    idle(); idle();
    chk("strobe_word_b", m_b[3], 32'h0022_0044);

    wr(4'd5, 32'hDEAD_BEEF, 4'hF);
    drive(1'b1, 4'd5, 32'hCAFE_F00D, 4'b1100, 1'b1, 4'd5);
    rd(4'd5);
    drive(1'b1, 4'd8, 32'h8888_8888, 4'hF, 1'b1, 4'd7);
    drive(1'b1, 4'd4, 32'h0BAD_0BAD, 4'h0, 1'b1, 4'd4);
    idle(); idle();

    for (int a = 0; a < 12; a++) wr(4'(a), 32'h0101_0101 * a + 32'h10, 4'hF);
    for (int a = 0; a < 12; a++) rd(4'(a));
    idle(); idle();

    wr(4'd13, 32'hFFFF_FFFF, 4'hF);
    rd(4'd13);
    rd(4'd12);
    rd(4'd15);
    for (int a = 0; a < 12; a++) rd(4'(a));
    idle(); idle();

    rd(4'd0);
    rd(4'd1);
    rd(4'd2);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_a_valid", {31'b0, val_a}, 32'd0);
    chk("rst_b_valid", {31'b0, val_b}, 32'd0);
    chk("rst_a_done", {31'b0, done_a}, 32'd0);
    chk("rst_b_done", {31'b0, done_b}, 32'd0);
    chk("rst_a_data", data_a, 32'h0);
    model_reset();
    rd(4'd3);
    rd(4'd4);
    RST_N = 1'b1;

    n_init = 0;
    while (!ready_m && n_init < 40) begin
      drive(1'b1, 4'd6, 32'h1234_5678, 4'hF, 1'b1, 4'd6);
      n_init++;
    end
    chk("reinit_cycles", n_init, 32'd12);
    for (int a = 0; a < 12; a++) rd(4'(a));
    idle(); idle(); idle();

    chk("queue_a_empty", q_a.size(), 32'd0);
    chk("queue_b_empty", q_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
